analyzer_capture_ctrl: RTL and testbench

Capture sequencer for the logic analyzer waveform buffer. It takes an arm request and the qualified trigger from the trigger logic and runs the pre-trigger, wait and post-trigger phases. It drives the write port of the single-clock dual-port wave RAM as a circular buffer and remaps host read addresses so that logical address 0 is always the oldest retained sample. It sits between the analyzer register/AXI slave logic and the wave RAM, replacing ad-hoc write-pointer logic in the datastore.

---
 rtl/analyzer_capture_ctrl.sv | 149 ++++++++++++++
 tb/tb_analyzer_capture_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/analyzer_capture_ctrl.sv
// Capture sequencer for the analyzer wave RAM: pre-trigger, wait and post-trigger phases over a circular buffer.
// Optional sample-rate prescaler is enabled with ANALYZER_CAPTURE_CTRL_DIV_EN.
module analyzer_capture_ctrl #(
    parameter int WAVE_ADDR_WIDTH = 12,
    parameter int DIGITAL_IN_NUM  = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [DIGITAL_IN_NUM-1:0]  digital_in,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       trig,
    input  logic [WAVE_ADDR_WIDTH-1:0] pre_depth,
`ifdef ANALYZER_CAPTURE_CTRL_DIV_EN
    input  logic [15:0]                sample_div,
`endif
    output logic                       busy,
    output logic                       armed,
    output logic                       done,
    output logic                       ram_wr_en,
    output logic [WAVE_ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DIGITAL_IN_NUM-1:0]  ram_wr_data,
    input  logic [WAVE_ADDR_WIDTH-1:0] rd_addr,
    output logic [WAVE_ADDR_WIDTH-1:0] ram_rd_addr,
    output logic [2:0]                 state_dbg
);

    // start/abort/trig are single-cycle level samples taken at posedge clk; a write is
    // presented on ram_wr_en/addr/data for exactly one cycle, one cycle after its tick.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [WAVE_ADDR_WIDTH-1:0] ADDR_ONE = WAVE_ADDR_WIDTH'(1);

    state_t                     state;
    logic [WAVE_ADDR_WIDTH-1:0] wr_ptr;
    logic [WAVE_ADDR_WIDTH-1:0] count;
    logic [WAVE_ADDR_WIDTH-1:0] pd;
    logic [WAVE_ADDR_WIDTH-1:0] post_cnt;
    logic [WAVE_ADDR_WIDTH-1:0] start_addr;
    logic                       tick;

    assign busy      = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
    assign armed     = (state == S_WAIT);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

    assign ram_rd_addr = start_addr + rd_addr;

`ifdef ANALYZER_CAPTURE_CTRL_DIV_EN
    logic [15:0] div_cnt;
    logic [15:0] div_lat;
    logic        capture_end;

    assign tick = busy && (div_cnt == 16'd0);
    // Last write tick of a capture; the prescaler must read 0 in the following DONE cycle.
    assign capture_end = tick && (((state == S_POST) && (post_cnt == ADDR_ONE)) ||
                                  ((state == S_WAIT) && trig && (pd == '1)));
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            count       <= '0;
            pd          <= '0;
            post_cnt    <= '0;
            start_addr  <= '0;
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
`ifdef ANALYZER_CAPTURE_CTRL_DIV_EN
            div_cnt     <= '0;
            div_lat     <= '0;
`endif
        end else begin
            ram_wr_en <= 1'b0;
`ifdef ANALYZER_CAPTURE_CTRL_DIV_EN
            if (busy && !abort && !capture_end && (div_cnt != div_lat))
                div_cnt <= div_cnt + 16'd1;
            else
                div_cnt <= 16'd0;
`endif
            if (abort) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            wr_ptr <= '0;
                            count  <= '0;
                            // pre_depth cannot exceed DEPTH-1 at this width, so no clamp is needed.
                            pd     <= pre_depth;
                            state  <= (pre_depth != '0) ? S_PRE : S_WAIT;
`ifdef ANALYZER_CAPTURE_CTRL_DIV_EN
                            div_lat <= sample_div;
`endif
                        end
                    end
                    S_PRE: begin
                        if (tick) begin
                            ram_wr_en   <= 1'b1;
                            ram_wr_addr <= wr_ptr;
                            ram_wr_data <= digital_in;
                            wr_ptr      <= wr_ptr + ADDR_ONE;
                            count       <= count + ADDR_ONE;
                            if ((count + ADDR_ONE) == pd)
                                state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (tick) begin
                            ram_wr_en   <= 1'b1;
                            ram_wr_addr <= wr_ptr;
                            ram_wr_data <= digital_in;
                            wr_ptr      <= wr_ptr + ADDR_ONE;
                            if (trig) begin
                                start_addr <= wr_ptr - pd;
                                // DEPTH-1-pd is the bitwise complement of pd.
                                post_cnt   <= ~pd;
                                state      <= (~pd == '0) ? S_DONE : S_POST;
                            end
                        end
                    end
                    S_POST: begin
                        if (tick) begin
                            ram_wr_en   <= 1'b1;
                            ram_wr_addr <= wr_ptr;
                            ram_wr_data <= digital_in;
                            wr_ptr      <= wr_ptr + ADDR_ONE;
                            post_cnt    <= post_cnt - ADDR_ONE;
                            if (post_cnt == ADDR_ONE)
                                state <= S_DONE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_analyzer_capture_ctrl.sv
// Directed bench for analyzer_capture_ctrl with DEPTH 16; writes are collected by a monitor and
// compared against an expected queue of {addr, data} entries.
module tb_analyzer_capture_ctrl;

    localparam int W = 4;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [N-1:0] digital_in = '0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         trig = 1'b0;
    logic [W-1:0] pre_depth = '0;
    logic [W-1:0] rd_addr = '0;
    logic         busy, armed, done, ram_wr_en;
    logic [W-1:0] ram_wr_addr, ram_rd_addr;
    logic [N-1:0] ram_wr_data;
    logic [2:0]   state_dbg;
`ifdef ANALYZER_CAPTURE_CTRL_DIV_EN
    logic [15:0]  sample_div = '0;
`endif

    analyzer_capture_ctrl #(.WAVE_ADDR_WIDTH(W), .DIGITAL_IN_NUM(N)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .digital_in  (digital_in),
        .start       (start),
        .abort       (abort),
        .trig        (trig),
        .pre_depth   (pre_depth),
`ifdef ANALYZER_CAPTURE_CTRL_DIV_EN
        .sample_div  (sample_div),
`endif
        .busy        (busy),
        .armed       (armed),
        .done        (done),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .rd_addr     (rd_addr),
        .ram_rd_addr (ram_rd_addr),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  din_ctr = 8'h10;
    logic [7:0]  d0;
    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];

    always @(negedge clk)
        if (rstn && ram_wr_en) obs_q.push_back({ram_wr_addr, ram_wr_data});

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // driver: one clock cycle with the given controls, fresh digital_in each cycle
    task automatic cyc(input logic s, input logic a, input logic t);
        start      = s;
        abort      = a;
        trig       = t;
        digital_in = din_ctr;
        din_ctr    = din_ctr + 8'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        trig  = 1'b0;
    endtask

    task automatic idle(input int n, input logic t);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, t);
    endtask

    // n consecutive writes from address 0 upward (mod 16); tick i samples d0+1+i
    task automatic expect_run(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++)
            exp_q.push_back({4'(i), 8'(base + 8'(i) + 8'd1)});
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_cnt"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0)
            check(tag, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic rd_check(input logic [W-1:0] a, input logic [W-1:0] exp);
        rd_addr = a;
        #1;
        check("rd_map", 32'(ram_rd_addr), 32'(exp));
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_armed", 32'(armed), 0);
        check("rst_done", 32'(done), 0);
        check("rst_wr_en", 32'(ram_wr_en), 0);
        check("rst_wr_addr", 32'(ram_wr_addr), 0);
        check("rst_wr_data", 32'(ram_wr_data), 0);
        check("rst_state", 32'(state_dbg), 0);
        rd_check(4'd3, 4'd3);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // pd=4, trigger on the write to address 6
        pre_depth = 4'd4;
        d0 = din_ctr;
        cyc(1'b1, 1'b0, 1'b0);
        check("a_busy", 32'(busy), 1);
        check("a_pre_state", 32'(state_dbg), 1);
        idle(6, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        idle(10, 1'b0);
        check("a_done_early", 32'(done), 0);
        cyc(1'b0, 1'b0, 1'b0);
        check("a_done", 32'(done), 1);
        check("a_busy_end", 32'(busy), 0);
        check("a_last_en", 32'(ram_wr_en), 1);
        check("a_last_addr", 32'(ram_wr_addr), 1);
        cyc(1'b0, 1'b0, 1'b0);
        check("a_no_wr", 32'(ram_wr_en), 0);
        expect_run(18, d0);
        check_writes("a_wr");
        rd_check(4'd0, 4'd2);
        rd_check(4'd15, 4'd1);

        // pd=4 with trig held high from the start cycle
        d0 = din_ctr;
        cyc(1'b1, 1'b0, 1'b1);
        idle(4, 1'b1);
        check("b_armed", 32'(armed), 1);
        idle(11, 1'b1);
        check("b_done_early", 32'(done), 0);
        cyc(1'b0, 1'b0, 1'b1);
        check("b_done", 32'(done), 1);
        cyc(1'b0, 1'b0, 1'b0);
        expect_run(16, d0);
        check_writes("b_wr");
        rd_check(4'd5, 4'd5);

        // pd=0, trig in the start cycle and the next
        pre_depth = 4'd0;
        d0 = din_ctr;
        cyc(1'b1, 1'b0, 1'b1);
        check("c_armed", 32'(armed), 1);
        cyc(1'b0, 1'b0, 1'b1);
        check("c_post_state", 32'(state_dbg), 3);
        idle(14, 1'b0);
        check("c_done_early", 32'(done), 0);
        cyc(1'b0, 1'b0, 1'b0);
        check("c_done", 32'(done), 1);
        cyc(1'b0, 1'b0, 1'b0);
        expect_run(16, d0);
        check_writes("c_wr");
        rd_check(4'd15, 4'd15);

        // wrap: pd=2, trigger on the write to address 3 after wrapping
        pre_depth = 4'd2;
        d0 = din_ctr;
        cyc(1'b1, 1'b0, 1'b0);
        idle(19, 1'b0);
        check("d_still_armed", 32'(armed), 1);
        cyc(1'b0, 1'b0, 1'b1);
        check("d_post_state", 32'(state_dbg), 3);
        idle(12, 1'b0);
        check("d_done_early", 32'(done), 0);
        cyc(1'b0, 1'b0, 1'b0);
        check("d_done", 32'(done), 1);
        check("d_last_addr", 32'(ram_wr_addr), 0);
        cyc(1'b0, 1'b0, 1'b0);
        expect_run(33, d0);
        check_writes("d_wr");
        rd_check(4'd15, 4'd0);
        rd_check(4'd0, 4'd1);

        // start during PRE ignored, abort in POST
        pre_depth = 4'd4;
        d0 = din_ctr;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        pre_depth = 4'd1;
        cyc(1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        check("e_armed", 32'(armed), 1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        check("e_post_state", 32'(state_dbg), 3);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        check("e_abort_busy", 32'(busy), 0);
        check("e_abort_done", 32'(done), 0);
        check("e_abort_wr_en", 32'(ram_wr_en), 0);
        check("e_abort_state", 32'(state_dbg), 0);
        cyc(1'b0, 1'b0, 1'b0);
        check("e_idle_wr_en", 32'(ram_wr_en), 0);
        expect_run(7, d0);
        check_writes("e_wr");
        rd_check(4'd0, 4'd1);

        // start and abort together
        pre_depth = 4'd4;
        cyc(1'b1, 1'b1, 1'b0);
        check("f_busy", 32'(busy), 0);
        check("f_state", 32'(state_dbg), 0);
        cyc(1'b0, 1'b0, 1'b0);
        check("f_wr_en", 32'(ram_wr_en), 0);
        check("f_no_writes", 32'(obs_q.size()), 0);

        // asynchronous reset mid-POST
        pre_depth = 4'd0;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        idle(3, 1'b0);
        check("g_pre_rst_wr_en", 32'(ram_wr_en), 1);
        rstn = 1'b0;
        #1;
        check("g_rst_wr_en", 32'(ram_wr_en), 0);
        check("g_rst_busy", 32'(busy), 0);
        check("g_rst_wr_addr", 32'(ram_wr_addr), 0);
        check("g_rst_wr_data", 32'(ram_wr_data), 0);
        check("g_rst_done", 32'(done), 0);
        @(posedge clk);
        #1;
        check("g_rst_state", 32'(state_dbg), 0);
        rd_check(4'd7, 4'd7);
        rstn = 1'b1;
        idle(2, 1'b0);
        check("g_post_done", 32'(done), 0);
        check("g_post_wr_en", 32'(ram_wr_en), 0);
        obs_q.delete();

`ifdef ANALYZER_CAPTURE_CTRL_DIV_EN
        // divided tick: one write every third cycle
        sample_div = 16'd2;
        pre_depth  = 4'd0;
        cyc(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 1'b0, 1'b0);
            check("div_wr_en", 32'(ram_wr_en), 32'(k % 3 == 0));
        end
        cyc(1'b0, 1'b1, 1'b0);
        sample_div = 16'd0;
        obs_q.delete();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
